stat_display_seq: RTL

Sequencer between the activity tracker and the four-digit seven-segment scanner. It holds four 16-bit binary statistics and shows one at a time, moving to the next statistic every two seconds. For each display it converts the selected value to four 5-bit digit codes using a bit-serial double-dabble conversion, then drives the display's bcd3..bcd0 inputs. It replaces the tracker's direct BCD outputs, so the tracker counts in binary only.

---
 rtl/stat_disp_pkg.sv | 24 ++
 rtl/bin2bcd_seq.sv | 59 +++++
 rtl/stat_display_seq.sv | 134 +++++++++++++
 3 files changed

// File: rtl/stat_disp_pkg.sv
// Shared constants, FSM state type and the double-dabble digit adjust used by the
// statistic display sequencer.
package stat_disp_pkg;

  localparam logic [3:0]  DIG_BLANK = 4'hF;
  localparam logic [15:0] SAT_MAX   = 16'd9999;
  localparam int          CONV_BITS = 16;

  localparam logic [1:0] STAT_STEPS  = 2'd0;
  localparam logic [1:0] STAT_DIST   = 2'd1;
  localparam logic [1:0] STAT_OVER32 = 2'd2;
  localparam logic [1:0] STAT_HIGH   = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_e;

  function automatic logic [3:0] dd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Bit-serial double-dabble: 16 shift cycles after start, then one DONE cycle in which
// bcd_o holds the four decimal digits of the loaded value.
module bin2bcd_seq
  import stat_disp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [15:0] value_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [15:0] bcd_o
);

  conv_state_e state_q;
  logic [3:0]  cnt_q;
  logic [15:0] bin_q;
  logic [15:0] acc_q;
  logic [15:0] acc_adj;

  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      acc_adj[i*4 +: 4] = dd_adjust(acc_q[i*4 +: 4]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bin_q   <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            bin_q   <= value_i;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          {acc_q, bin_q} <= {acc_adj[14:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + 4'd1;
          if (cnt_q == 4'(CONV_BITS - 1)) state_q <= DONE;
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE);
  assign bcd_o  = acc_q;

endmodule

// File: rtl/stat_display_seq.sv
// Rotates four binary statistics onto the 4-digit display, two ticks per statistic.
// Leading-zero blanking is enabled by defining STAT_DISP_LZB_EN.
module stat_display_seq
  import stat_disp_pkg::*;
#(
  parameter int          NSTAT   = 4,
  parameter logic [15:0] SAT_MAX = 16'd9999
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     tick_1hz,
  input  logic                     freeze,
  input  logic [15:0]              step_count,
  input  logic [15:0]              dist_tenths,
  input  logic [15:0]              secs_over32,
  input  logic [15:0]              secs_high,
  output logic [4:0]               bcd3,
  output logic [4:0]               bcd2,
  output logic [4:0]               bcd1,
  output logic [4:0]               bcd0,
  output logic [$clog2(NSTAT)-1:0] stat_sel,
  output logic                     busy,
  output logic                     done_p
);

  localparam int SW = $clog2(NSTAT);

`ifdef STAT_DISP_LZB_EN
  localparam logic [4:0] RST_DIG = {1'b0, DIG_BLANK};
`else
  localparam logic [4:0] RST_DIG = 5'h00;
`endif

  logic          sec_par_q;
  logic          pend_q;
  logic [SW-1:0] next_sel_q;
  logic [SW-1:0] stat_sel_q;
  logic [4:0]    bcd3_q, bcd2_q, bcd1_q, bcd0_q;
  logic          done_p_q;

  logic          conv_busy, conv_done;
  logic [15:0]   conv_bcd;
  logic          service;
  logic [SW-1:0] sel_inc, sel_new;
  logic [15:0]   raw_val, clamped;
  logic [3:0]    d3, d2, d1, d0;
  logic          is_dist, blank3, blank2, blank1;
  logic [4:0]    fmt3, fmt2, fmt1, fmt0;

  // A held-over tick is treated exactly like a fresh one once the engine is idle.
  assign service = (tick_1hz | pend_q) & ~conv_busy;

  always_comb begin
    sel_inc = (next_sel_q == SW'(NSTAT - 1)) ? '0 : next_sel_q + 1'b1;
    sel_new = (sec_par_q && !freeze) ? sel_inc : next_sel_q;
    case (sel_new)
      STAT_STEPS:  raw_val = step_count;
      STAT_DIST:   raw_val = dist_tenths;
      STAT_OVER32: raw_val = secs_over32;
      default:     raw_val = secs_high;
    endcase
    clamped = (raw_val > SAT_MAX) ? SAT_MAX : raw_val;
  end

  bin2bcd_seq u_conv (
    .clk     (clk),
    .rst     (rst),
    .start_i (service),
    .value_i (clamped),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd)
  );

  always_comb begin
    d3      = conv_bcd[15:12];
    d2      = conv_bcd[11:8];
    d1      = conv_bcd[7:4];
    d0      = conv_bcd[3:0];
    is_dist = (next_sel_q == STAT_DIST);
`ifdef STAT_DISP_LZB_EN
    blank3  = (d3 == 4'd0);
    blank2  = blank3 && (d2 == 4'd0);
    blank1  = blank2 && (d1 == 4'd0) && !is_dist;
`else
    blank3  = 1'b0;
    blank2  = 1'b0;
    blank1  = 1'b0;
`endif
    fmt3 = {1'b0,    blank3 ? DIG_BLANK : d3};
    fmt2 = {1'b0,    blank2 ? DIG_BLANK : d2};
    fmt1 = {is_dist, blank1 ? DIG_BLANK : d1};
    fmt0 = {1'b0,    d0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_par_q  <= 1'b0;
      pend_q     <= 1'b0;
      next_sel_q <= '0;
      stat_sel_q <= '0;
      bcd3_q     <= RST_DIG;
      bcd2_q     <= RST_DIG;
      bcd1_q     <= RST_DIG;
      bcd0_q     <= 5'h00;
      done_p_q   <= 1'b0;
    end else begin
      if (service) begin
        pend_q     <= 1'b0;
        sec_par_q  <= ~sec_par_q;
        next_sel_q <= sel_new;
      end else if (tick_1hz && conv_busy) begin
        pend_q <= 1'b1;
      end
      done_p_q <= conv_done;
      if (conv_done) begin
        bcd3_q     <= fmt3;
        bcd2_q     <= fmt2;
        bcd1_q     <= fmt1;
        bcd0_q     <= fmt0;
        stat_sel_q <= next_sel_q;
      end
    end
  end

  assign bcd3     = bcd3_q;
  assign bcd2     = bcd2_q;
  assign bcd1     = bcd1_q;
  assign bcd0     = bcd0_q;
  assign stat_sel = stat_sel_q;
  assign busy     = conv_busy;
  assign done_p   = done_p_q;

endmodule
